// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg: opcodes, shadow-stage types and operand decode helpers
package hazard_unit_pkg;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [4:0] REG_X0    = 5'd0;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } ex_stage_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
    } mem_stage_t;

    function automatic logic reads_rs2(input logic [6:0] op);
        return op == OP_RTYPE || op == OP_STORE || op == OP_BRANCH;
    endfunction

    function automatic logic reads_rs1(input logic [6:0] op);
        return reads_rs2(op) || op == OP_LOAD || op == OP_IALU;
    endfunction

    function automatic logic writes_rd(input logic [6:0] op);
        return op == OP_LOAD || op == OP_RTYPE || op == OP_IALU;
    endfunction

    function automatic logic src_hit(input logic use1, input logic [4:0] rs1,
                                     input logic use2, input logic [4:0] rs2,
                                     input logic [4:0] rd);
        return rd != REG_X0 && ((use1 && rs1 == rd) || (use2 && rs2 == rd));
    endfunction
endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: ID-stage operands in, stall/flush controls and counters out
interface hazard_unit_if #(parameter int CNT_W = 16);
    logic             id_valid;
    logic [6:0]       id_opcode;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       id_rd;
    logic             ex_branch_taken;
    logic             stall;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_branch_taken,
        input  stall, pc_write, ifid_write, ifid_flush, idex_flush, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_branch_taken,
        output stall, pc_write, ifid_write, ifid_flush, idex_flush, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_sat_counter.sv
// hazard_sat_counter: enabled up-counter that holds at all-ones
module hazard_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else if (en && q != '1) q <= q + 1'b1;
    end
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush control driven by a shadow EX/MEM destination pipeline
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter bit FORWARDING = 1'b1,
    parameter int CNT_W      = 16
) (
    input logic          clk,
    input logic          rst,
    hazard_unit_if.slave hu
);
    ex_stage_t  s_ex;
    ex_stage_t  id_dec;
    mem_stage_t s_mem;
    logic use1, use2, load_use, raw, hz, br, hold;

    always_comb begin
        use1     = reads_rs1(hu.id_opcode) && hu.id_rs1 != REG_X0;
        use2     = reads_rs2(hu.id_opcode) && hu.id_rs2 != REG_X0;
        id_dec   = '{valid: 1'b1, rd: hu.id_rd, regwrite: writes_rd(hu.id_opcode),
                     memread: hu.id_opcode == OP_LOAD};
        load_use = s_ex.valid && s_ex.memread && src_hit(use1, hu.id_rs1, use2, hu.id_rs2, s_ex.rd);
        raw      = (s_ex.valid && s_ex.regwrite && src_hit(use1, hu.id_rs1, use2, hu.id_rs2, s_ex.rd)) ||
                   (s_mem.valid && s_mem.regwrite && src_hit(use1, hu.id_rs1, use2, hu.id_rs2, s_mem.rd));
        hz       = hu.id_valid && (FORWARDING ? load_use : raw);
        br       = hu.ex_branch_taken && !rst;
        hold     = hz && !br && !rst;
    end

    assign hu.stall      = hold;
    assign hu.pc_write   = !hold;
    assign hu.ifid_write = !hold;
    assign hu.ifid_flush = br;
    assign hu.idex_flush = br;

    // A bubble enters the shadow EX stage whenever ID/EX is stalled or flushed
    always_ff @(posedge clk) begin
        if (rst) begin
            s_ex  <= '0;
            s_mem <= '0;
        end else begin
            s_mem <= '{valid: s_ex.valid, rd: s_ex.rd, regwrite: s_ex.regwrite};
            s_ex  <= (hold || br || !hu.id_valid) ? '0 : id_dec;
        end
    end

    hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .en  (hold),
        .q   (hu.stall_cnt)
    );

    hazard_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .en  (hu.ex_branch_taken),
        .q   (hu.flush_cnt)
    );
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard controller that produces the `stall` input consumed by the control unit.
- Also produces PC / IF-ID write enables and flush strobes for the 5-stage RISC-V core.
- Keeps its own shadow pipeline of in-flight destination registers for the EX and MEM stages, so it detects data hazards from ID-stage operands alone.
- Reacts to a branch resolved in EX by flushing younger instructions; keeps saturating stall/flush performance counters.

Parameters:
- FORWARDING, 1, 1 = forwarding paths exist (stall only on load-use); 0 = stall on any RAW against EX or MEM.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  input  1  core clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_opcode  input  7  opcode of ID instruction.
- id_rs1  input  5  source register 1 of ID instruction.
- id_rs2  input  5  source register 2 of ID instruction.
- id_rd  input  5  destination register of ID instruction.
- ex_branch_taken  input  1  branch in EX resolved taken this cycle.
- stall  output  1  to control unit; forces bubble into ID/EX.
- pc_write  output  1  PC register write enable.
- ifid_write  output  1  IF/ID register write enable.
- ifid_flush  output  1  clear IF/ID to NOP.
- idex_flush  output  1  clear ID/EX to NOP.
- stall_cnt  output  CNT_W  cycles with stall asserted, saturating.
- flush_cnt  output  CNT_W  taken-branch flush events, saturating.

Behaviour:
- Operand use by opcode:
  - R-type 0110011, store 0100011, branch 1100011 read rs1 and rs2.
  - Load 0000011 and I-ALU 0010011 read rs1 only.
  - All other opcodes read nothing.
  - Writers are load, R-type and I-ALU only.
  - Register x0 never creates a hazard, either as source or destination.
- Shadow stages:
  - S_EX = {valid, rd, regwrite, memread}; S_MEM = {valid, rd, regwrite}.
  - Each clock: S_MEM <= S_EX.
  - S_EX <= bubble (all zero) if stall, idex_flush or !id_valid; otherwise <= the decoded ID instruction.
- Hazard (combinational, from current shadow state and ID inputs):
  - load_use = S_EX.valid & S_EX.memread & S_EX.rd != 0 & an ID source in use equals S_EX.rd.
  - FORWARDING=1: hz = load_use.
  - FORWARDING=0: hz = any in-use ID source matches a valid regwrite S_EX.rd or S_MEM.rd (rd != 0). The WB stage is covered by a write-first register file.
  - hz is qualified by id_valid.
- Outputs, with branch taking priority:
  - ex_branch_taken=1: ifid_flush=1, idex_flush=1, stall=0, pc_write=1, ifid_write=1. The flush overrides any concurrent hazard, because the dependent instruction is discarded.
  - else hz=1: stall=1, pc_write=0, ifid_write=0, flushes 0.
  - else: stall=0, pc_write=1, ifid_write=1, flushes 0.
- Latency:
  - A load-use hazard holds stall for exactly one cycle; the load then moves to S_MEM and forwarding resolves it.
  - With FORWARDING=0, a back-to-back RAW holds stall for 2 cycles.
- Counters:
  - stall_cnt increments on each cycle with stall=1.
  - flush_cnt increments on each cycle with ex_branch_taken=1.
  - Both hold at 2^CNT_W-1 (no wrap).
- Reset, synchronous:
  - Shadow stages cleared (valid=0) and counters = 0.
  - While rst=1, outputs are forced: stall=0, pc_write=1, ifid_write=1, ifid_flush=0, idex_flush=0.
  - Reset mid-stall abandons the stall; the first cycle after reset has no hazard.

Decomposition:
- Shared package holds:
  - opcode constants OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH, OP_IALU (shared with the control unit);
  - the shadow-stage struct typedef;
  - the REG_X0 constant.
- One natural sub-module, `hazard_sat_counter` (CNT_W-bit saturating counter with enable and sync reset), instantiated twice.

Test Plan:
- Load x5 followed by add x6,x5,x7 (FORWARDING=1) -> stall=1, pc_write=0, ifid_write=0 for exactly 1 cycle; stall_cnt=1.
- Load x0 followed by add x6,x0,x0 -> no stall; load x5 followed by I-ALU using only rs1=x7, rs2 field=5 -> no stall.
- Load x5 hazard with ex_branch_taken=1 in the same cycle -> stall=0, ifid_flush=1, idex_flush=1, flush_cnt=1.
- FORWARDING=0: addi x3 then sub x4,x3,x1 -> stall for 2 consecutive cycles, then released; stall_cnt=2.
- Assert rst during an active stall -> next cycle stall=0, pc_write=1, counters=0, shadow stages empty.
- CNT_W=4: 20 consecutive taken branches -> flush_cnt reaches 15 and holds.
